// File: rtl/iic_slave.sv
// I2C register-access slave: synchronized, glitch-filtered SCL/SDA; reg_we/reg_re strobes a few clk after SCL edges.
// No backpressure: reg_rdata must be valid on the 2nd clk after reg_re; SCL is never stretched.
module iic_slave #(
    parameter logic [6:0] DEV_ID    = 7'h3C,
    parameter int         ADDR_BYTE = 1,
    parameter int         FILT_LEN  = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic                   sda_out,
    output logic                   sda_out_en,
    output logic [ADDR_BYTE*8-1:0] reg_addr,
    output logic [7:0]             reg_wdata,
    output logic                   reg_we,
    output logic                   reg_re,
    input  logic [7:0]             reg_rdata,
    output logic                   busy
);
    localparam int         AW       = ADDR_BYTE * 8;
    localparam logic [1:0] LAST_IDX = 2'(ADDR_BYTE - 1);
    localparam logic [1:0] NBYTES   = 2'(ADDR_BYTE);
    localparam logic [7:0] SETTLE   = 8'(FILT_LEN + 4);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
    } state_t;

    logic [1:0]          scl_sync, sda_sync;
    logic [FILT_LEN-1:0] scl_hist, sda_hist;
    logic                scl_f, sda_f, scl_fd, sda_fd;
    logic [7:0]          settle;
    logic                armed, start_det, stop_det, scl_rise, scl_fall;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_fd   <= 1'b1;
            sda_fd   <= 1'b1;
            settle   <= '0;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= (scl_hist << 1) | FILT_LEN'(scl_sync[1]);
            sda_hist <= (sda_hist << 1) | FILT_LEN'(sda_sync[1]);
            if (&scl_hist)       scl_f <= 1'b1;
            else if (~|scl_hist) scl_f <= 1'b0;
            if (&sda_hist)       sda_f <= 1'b1;
            else if (~|sda_hist) sda_f <= 1'b0;
            scl_fd <= scl_f;
            sda_fd <= sda_f;
            if (settle != SETTLE) settle <= settle + 8'd1;
        end
    end

    // Edges are ignored until the filters have converged on the real bus levels after reset.
    assign armed     = (settle == SETTLE);
    assign start_det = armed & scl_f & scl_fd & sda_fd & ~sda_f;
    assign stop_det  = armed & scl_f & scl_fd & ~sda_fd & sda_f;
    assign scl_rise  = armed & scl_f & ~scl_fd;
    assign scl_fall  = armed & ~scl_f & scl_fd;
    assign sda_out   = 1'b0;

    state_t          state, state_nx;
    logic [3:0]      bit_cnt, bit_cnt_nx;
    logic [7:0]      shreg, shreg_nx, wdata_nx;
    logic [1:0]      byte_idx, byte_idx_nx;
    logic [AW-1:0]   addr_acc, addr_acc_nx, addr_nx;
    logic [AW+7:0]   addr_join;
    logic            rw, rw_nx, en_nx, we_nx, re_nx, busy_nx;
    logic            ld_pend, ld_nx, drv_pend, drv_nx;

    assign addr_join = {addr_acc, shreg};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_idx   <= '0;
            addr_acc   <= '0;
            rw         <= 1'b0;
            sda_out_en <= 1'b0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
            reg_wdata  <= '0;
            reg_addr   <= '0;
            ld_pend    <= 1'b0;
            drv_pend   <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            shreg      <= shreg_nx;
            byte_idx   <= byte_idx_nx;
            addr_acc   <= addr_acc_nx;
            rw         <= rw_nx;
            sda_out_en <= en_nx;
            reg_we     <= we_nx;
            reg_re     <= re_nx;
            busy       <= busy_nx;
            reg_wdata  <= wdata_nx;
            reg_addr   <= addr_nx;
            ld_pend    <= ld_nx;
            drv_pend   <= drv_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        byte_idx_nx = byte_idx;
        addr_acc_nx = addr_acc;
        rw_nx       = rw;
        en_nx       = sda_out_en;
        we_nx       = 1'b0;
        re_nx       = 1'b0;
        busy_nx     = busy;
        wdata_nx    = reg_wdata;
        addr_nx     = reg_addr;
        ld_nx       = reg_re;
        drv_nx      = 1'b0;

        // Read pipeline: reg_re -> 2 clk -> latch rdata -> 1 clk -> drive bit 7.
        if (reg_we)   addr_nx  = reg_addr + AW'(1);
        if (ld_pend) begin
            shreg_nx = reg_rdata;
            drv_nx   = 1'b1;
        end
        if (drv_pend) en_nx = ~shreg[7];

        if (start_det) begin
            state_nx   = DEV;
            bit_cnt_nx = '0;
            en_nx      = 1'b0;
            busy_nx    = 1'b1;
            ld_nx      = 1'b0;
            drv_nx     = 1'b0;
        end else if (stop_det) begin
            state_nx = IDLE;
            en_nx    = 1'b0;
            busy_nx  = 1'b0;
            ld_nx    = 1'b0;
            drv_nx   = 1'b0;
        end else begin
            case (state)
                DEV, ADDR, WDATA: begin
                    if (scl_rise && !bit_cnt[3]) begin
                        shreg_nx   = {shreg[6:0], sda_f};
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt[3]) begin
                        bit_cnt_nx = '0;
                        en_nx      = 1'b1;
                        if (state == DEV) begin
                            if (shreg[7:1] == DEV_ID) begin
                                state_nx = DEV_ACK;
                                rw_nx    = shreg[0];
                            end else begin
                                state_nx = WAIT_STOP;
                                en_nx    = 1'b0;
                            end
                        end else if (state == ADDR) begin
                            state_nx    = ADDR_ACK;
                            addr_acc_nx = addr_join[AW-1:0];
                            byte_idx_nx = byte_idx + 2'd1;
                            if (byte_idx == LAST_IDX) addr_nx = addr_join[AW-1:0];
                        end else begin
                            state_nx = WDATA_ACK;
                            wdata_nx = shreg;
                            we_nx    = 1'b1;
                        end
                    end
                end
                DEV_ACK: if (scl_fall) begin
                    en_nx      = 1'b0;
                    bit_cnt_nx = '0;
                    if (rw) begin
                        state_nx = RDATA;
                        re_nx    = 1'b1;
                    end else begin
                        state_nx    = ADDR;
                        byte_idx_nx = '0;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    en_nx    = 1'b0;
                    state_nx = (byte_idx == NBYTES) ? WDATA : ADDR;
                end
                WDATA_ACK: if (scl_fall) begin
                    en_nx    = 1'b0;
                    state_nx = WDATA;
                end
                RDATA: if (scl_fall) begin
                    if (bit_cnt == 4'd7) begin
                        en_nx      = 1'b0;
                        bit_cnt_nx = '0;
                        state_nx   = RACK;
                        addr_nx    = reg_addr + AW'(1);
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                        shreg_nx   = {shreg[6:0], 1'b0};
                        en_nx      = ~shreg[6];
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        shreg_nx[0] = sda_f;
                    end else if (scl_fall) begin
                        if (!shreg[0]) begin
                            state_nx = RDATA;
                            re_nx    = 1'b1;
                        end else begin
                            state_nx = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iic_slave.sv
// Bench for iic_slave: bit-banged I2C master on an open-drain bus shared by a 1-byte and a 2-byte-address slave.
module tb_iic_slave;
    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rstn, scl_m, sda_m;
    logic        sda_o1, en1, we1, re1, busy1;
    logic        sda_o2, en2, we2, re2, busy2;
    logic [7:0]  addr1, wdata1, rdata1, wdata2;
    logic [15:0] addr2;
    logic [7:0]  rdata2;
    logic [7:0]  rmem [256];
    logic        en_seen;
    logic        ack;
    logic [7:0]  rd;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [23:0] exp_we1_q[$];
    logic [23:0] exp_we2_q[$];
    logic [7:0]  exp_re1_q[$];

    wire sda_line = sda_m & ~en1 & ~en2;
    assign rdata1 = rmem[addr1];
    assign rdata2 = 8'h00;

    always #5 clk = ~clk;

    iic_slave #(.DEV_ID(7'h3C), .ADDR_BYTE(1), .FILT_LEN(3)) u_dut1 (
        .clk(clk), .rstn(rstn), .scl_in(scl_m), .sda_in(sda_line),
        .sda_out(sda_o1), .sda_out_en(en1), .reg_addr(addr1), .reg_wdata(wdata1),
        .reg_we(we1), .reg_re(re1), .reg_rdata(rdata1), .busy(busy1)
    );

    iic_slave #(.DEV_ID(7'h3D), .ADDR_BYTE(2), .FILT_LEN(3)) u_dut2 (
        .clk(clk), .rstn(rstn), .scl_in(scl_m), .sda_in(sda_line),
        .sda_out(sda_o2), .sda_out_en(en2), .reg_addr(addr2), .reg_wdata(wdata2),
        .reg_we(we2), .reg_re(re2), .reg_rdata(rdata2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: strobes are matched against expectations pushed by the stimulus.
    always @(negedge clk) begin
        if (rstn) begin
            if (we1) begin
                chk("we1_expected", 32'(exp_we1_q.size() > 0), 1);
                if (exp_we1_q.size() > 0) chk("we1_addr_data", {8'h0, 8'h0, addr1, wdata1}, {8'h0, exp_we1_q.pop_front()});
                chk("we1_re1_excl", re1, 0);
            end
            if (re1) begin
                chk("re1_expected", 32'(exp_re1_q.size() > 0), 1);
                if (exp_re1_q.size() > 0) chk("re1_addr", addr1, exp_re1_q.pop_front());
            end
            if (we2) begin
                chk("we2_expected", 32'(exp_we2_q.size() > 0), 1);
                if (exp_we2_q.size() > 0) chk("we2_addr_data", {8'h0, addr2, wdata2}, {8'h0, exp_we2_q.pop_front()});
            end
            if (re2) chk("re2_unexpected", re2, 0);
            if (en1 || en2) en_seen = 1'b1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        scl_m = 1'b0; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop;
        scl_m = 1'b0; sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        sda_m = b;
        wait_clk(Q / 2);
        if (glitch) begin
            scl_m = 1'b1; wait_clk(1); scl_m = 1'b0;
        end
        wait_clk(Q / 2);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_line; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
        read_bit(a);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; scl_m = 1'b1; sda_m = 1'b1; en_seen = 1'b0;
        for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
        wait_clk(5);
        chk("rst_sda_en", en1, 0);
        chk("rst_we", we1, 0);
        chk("rst_re", re1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_addr", addr1, 0);
        chk("rst_wdata", wdata1, 0);
        chk("rst_addr2", addr2, 0);
        rstn = 1'b1;
        wait_clk(20);

        // Single-byte write
        exp_we1_q.push_back({16'h0012, 8'hA5});
        i2c_start;
        chk("busy_after_start", busy1, 1);
        write_byte(8'h78, -1, ack); chk("w_dev_ack", ack, 0);
        write_byte(8'h12, -1, ack); chk("w_addr_ack", ack, 0);
        write_byte(8'hA5, -1, ack); chk("w_data_ack", ack, 0);
        i2c_stop;
        wait_clk(5);
        chk("w_addr_after", addr1, 8'h13);
        chk("busy_after_stop", busy1, 0);

        // Register read with repeated start, ACK then NACK
        rmem[8'h12] = 8'h5A; rmem[8'h13] = 8'hC3;
        exp_re1_q.push_back(8'h12); exp_re1_q.push_back(8'h13);
        i2c_start;
        write_byte(8'h78, -1, ack); chk("r_dev_ack", ack, 0);
        write_byte(8'h12, -1, ack); chk("r_addr_ack", ack, 0);
        i2c_start;
        write_byte(8'h79, -1, ack); chk("r_devr_ack", ack, 0);
        read_byte(1'b0, rd); chk("r_byte0", rd, 8'h5A);
        read_byte(1'b1, rd); chk("r_byte1", rd, 8'hC3);
        chk("r_release_after_nack", en1, 0);
        i2c_stop;
        wait_clk(5);
        chk("r_addr_after", addr1, 8'h14);

        // Nobody answers 0x28
        en_seen = 1'b0;
        i2c_start;
        write_byte(8'h50, -1, ack); chk("x_dev_nack", ack, 1);
        write_byte(8'h11, -1, ack); chk("x_data_nack", ack, 1);
        chk("x_no_drive", en_seen, 0);
        i2c_stop;

        // Pointer wrap 0xFF -> 0x00
        exp_we1_q.push_back({16'h00FF, 8'h01});
        exp_we1_q.push_back({16'h0000, 8'h02});
        i2c_start;
        write_byte(8'h78, -1, ack); chk("wr_dev_ack", ack, 0);
        write_byte(8'hFF, -1, ack); chk("wr_addr_ack", ack, 0);
        write_byte(8'h01, -1, ack); chk("wr_d0_ack", ack, 0);
        write_byte(8'h02, -1, ack); chk("wr_d1_ack", ack, 0);
        i2c_stop;
        wait_clk(5);
        chk("wr_addr_after", addr1, 8'h01);

        // Two-byte address slave, MSB first
        exp_we2_q.push_back({16'h3008, 8'h77});
        i2c_start;
        write_byte(8'h7A, -1, ack); chk("a2_dev_ack", ack, 0);
        write_byte(8'h30, -1, ack); chk("a2_msb_ack", ack, 0);
        write_byte(8'h08, -1, ack); chk("a2_lsb_ack", ack, 0);
        write_byte(8'h77, -1, ack); chk("a2_data_ack", ack, 0);
        i2c_stop;
        wait_clk(5);
        chk("a2_addr_after", addr2, 16'h3009);
        chk("a2_other_addr_kept", addr1, 8'h01);

        // 1-clk SCL glitch inside a data byte
        exp_we1_q.push_back({16'h0020, 8'h33});
        i2c_start;
        write_byte(8'h78, -1, ack);
        write_byte(8'h20, -1, ack);
        write_byte(8'h33, 4, ack); chk("g_data_ack", ack, 0);
        i2c_stop;
        wait_clk(5);
        chk("g_addr_after", addr1, 8'h21);

        // START after 4 data bits drops the partial byte
        exp_we1_q.push_back({16'h0060, 8'h44});
        i2c_start;
        write_byte(8'h78, -1, ack);
        write_byte(8'h50, -1, ack);
        write_bit(1'b1, 1'b0); write_bit(1'b0, 1'b0);
        write_bit(1'b1, 1'b0); write_bit(1'b0, 1'b0);
        i2c_start;
        chk("m_addr_kept", addr1, 8'h50);
        write_byte(8'h78, -1, ack); chk("m_dev_ack", ack, 0);
        write_byte(8'h60, -1, ack); chk("m_addr_ack", ack, 0);
        write_byte(8'h44, -1, ack); chk("m_data_ack", ack, 0);
        i2c_stop;
        wait_clk(5);
        chk("m_addr_after", addr1, 8'h61);

        // Reset while the slave drives a read bit
        rmem[8'h40] = 8'h5A;
        exp_re1_q.push_back(8'h40);
        i2c_start;
        write_byte(8'h78, -1, ack);
        write_byte(8'h40, -1, ack);
        i2c_start;
        write_byte(8'h79, -1, ack); chk("rr_dev_ack", ack, 0);
        for (int i = 0; i < 200 && !en1; i++) wait_clk(1);
        chk("rr_driving", en1, 1);
        rstn = 1'b0;
        wait_clk(1);
        chk("rr_release_on_reset", en1, 0);
        chk("rr_busy_reset", busy1, 0);
        chk("rr_addr_reset", addr1, 0);
        rstn = 1'b1;
        en_seen = 1'b0;
        read_bit(ack); read_bit(ack); read_bit(ack);
        chk("rr_ignored_after_reset", en_seen, 0);
        i2c_stop;

        // Recovery write after reset
        exp_we1_q.push_back({16'h0007, 8'h9C});
        i2c_start;
        write_byte(8'h78, -1, ack); chk("rc_dev_ack", ack, 0);
        write_byte(8'h07, -1, ack);
        write_byte(8'h9C, -1, ack); chk("rc_data_ack", ack, 0);
        i2c_stop;
        wait_clk(10);

        chk("we1_left", exp_we1_q.size(), 0);
        chk("we2_left", exp_we2_q.size(), 0);
        chk("re1_left", exp_re1_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/iic_slave.md
IIC_SLAVE -- requirements
Module: iic_slave

Interface
REQ-001 SHALL provide parameter DEV_ID, default 7'h3C: 7-bit bus address this slave responds to.
REQ-002 SHALL provide parameter ADDR_BYTE, default 1: register address width in bytes, legal values 1 or 2; any 2-byte address is sent MSB first.
REQ-003 SHALL provide parameter FILT_LEN, default 3: number of consecutive equal synchronized samples that accept a new SCL/SDA level.
REQ-004 clk  input  1  system clock; clk SHALL run at least 20x the SCL frequency.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 scl_in  input  1  bus SCL, asynchronous to clk.
REQ-007 sda_in  input  1  bus SDA, asynchronous to clk.
REQ-008 sda_out  output  1  SDA drive value; constant 0.
REQ-009 sda_out_en  output  1  1 = drive SDA low; 0 = release SDA.
REQ-010 reg_addr  output  ADDR_BYTE*8  current register pointer.
REQ-011 reg_wdata  output  8  received data byte; valid while reg_we is 1.
REQ-012 reg_we  output  1  one-clk write strobe.
REQ-013 reg_re  output  1  one-clk read-request strobe.
REQ-014 reg_rdata  input  8  read data, sampled on the 2nd clk after reg_re.
REQ-015 busy  output  1  1 from a detected START until a detected STOP.

Function
REQ-016 SCL and SDA SHALL each pass through a 2-flop synchronizer and then a FILT_LEN glitch filter; all edge and condition detection SHALL use the filtered levels.
REQ-017 START SHALL be detected when filtered SDA falls while filtered SCL is 1; STOP SHALL be detected when filtered SDA rises while filtered SCL is 1.
REQ-018 Bits SHALL be sampled on the filtered SCL rising edge; sda_out_en SHALL change only on the clk after a filtered SCL falling edge.
REQ-019 The state machine SHALL have these states: IDLE, DEV, DEV_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
REQ-020 Any START in any state, including a repeated START or a START mid-byte, SHALL go to DEV with the bit counter at 0; reg_addr SHALL be kept.
REQ-021 Any STOP SHALL go to IDLE, release SDA and clear busy.
REQ-022 DEV: after 8 bits, if bits[7:1] == DEV_ID, go to DEV_ACK and drive ACK (sda_out_en=1) for one SCL cycle; otherwise go to WAIT_STOP with SDA released.
REQ-023 After DEV_ACK: if R/W bit = 0, go to ADDR with the byte index at 0; if R/W bit = 1, go to RDATA.
REQ-024 ADDR: each byte SHALL be ACKed in ADDR_ACK; after ADDR_BYTE bytes, reg_addr SHALL be loaded with the assembled value and the next state SHALL be WDATA.
REQ-025 WDATA: after 8 bits, reg_wdata SHALL be loaded and reg_we SHALL pulse with the current reg_addr; the byte SHALL then be ACKed in WDATA_ACK; reg_addr SHALL increment one clk after reg_we; the machine SHALL stay in WDATA for further bytes.
REQ-026 RDATA entry: reg_re SHALL pulse on the SCL falling edge that ends DEV_ACK or RACK-with-ACK; reg_rdata SHALL be latched into the shift register 2 clk later; bit 7 SHALL be driven on the following clk (sda_out_en = ~bit).
REQ-027 After 8 read bits, SDA SHALL be released and the master's bit sampled in RACK; reg_addr SHALL increment on the falling edge that ends the 8th bit.
REQ-028 RACK: SDA=0 (ACK) SHALL go to RDATA; SDA=1 (NACK) SHALL go to WAIT_STOP with no further reg_re.
REQ-029 reg_addr increment SHALL wrap modulo 2^(8*ADDR_BYTE), e.g. 0xFF -> 0x00 when ADDR_BYTE=1.
REQ-030 A START or STOP arriving mid-byte SHALL discard the partial byte and SHALL produce no reg_we.
REQ-031 reg_we and reg_re SHALL never be 1 in the same clk.

Reset
REQ-032 When rstn=0 at a clk edge: state=IDLE, sda_out_en=0, reg_we=0, reg_re=0, busy=0, reg_addr=0, reg_wdata=0, synchronizer and filter outputs=1.
REQ-033 A reset mid-transfer SHALL release SDA on the next clk and SHALL ignore bus activity until the next START.

Verification
REQ-034 Write sequence S,0x78,0x12,0xA5,P -> three ACKs; one reg_we with reg_addr=0x12, reg_wdata=0xA5; reg_addr=0x13 afterwards.
REQ-035 Read sequence S,0x78,0x12,Sr,0x79,read 2 (ACK,NACK),P with reg_rdata=0x5A then 0xC3 -> reg_re at addresses 0x12 and 0x13; bus carries 0x5A,0xC3; SDA released after the NACK.
REQ-036 Sequence S,0x50,... -> no ACK, no reg_we or reg_re; sda_out_en stays 0 until P.
REQ-037 Pointer at 0xFF, write 0x01,0x02 -> reg_we at 0xFF then 0x00; with ADDR_BYTE=2, address 0x3008 is received as bytes 0x30,0x08.
REQ-038 Glitch of 1 clk on SCL -> ignored; START at bit 4 of a data byte -> no reg_we and a new address phase begins; rstn=0 during RDATA -> sda_out_en=0 on the next clk.
